// File: rtl/stopwatch_timebase.sv
// Stopwatch core: CLK/DIV timebase driving a BCD MM:SS.hh counter; LAP_EN adds the lap-freeze display hold.
// Latency: tick is combinational; digits update on the edge that ends a tick cycle. Controls act on the next edge.
// Backpressure: none; control inputs are single-cycle pulses that are always accepted.
module stopwatch_timebase #(
    parameter int CLK_HZ  = 27000000,
    parameter int TICK_HZ = 100,
    parameter int MAX_MIN = 59
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic       running,
    output logic       tick,
    output logic [7:0] hundredths_bcd,
    output logic [7:0] seconds_bcd,
    output logic [7:0] minutes_bcd,
    output logic       overflow,
    output logic       frozen
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST  = PW'(DIV - 1);
    localparam logic [3:0]    MAX_T = 4'(MAX_MIN / 10);
    localparam logic [3:0]    MAX_U = 4'(MAX_MIN % 10);

    generate
        if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
            $error("stopwatch_timebase: CLK_HZ/TICK_HZ must be an integer >= 2");
        end
        if (MAX_MIN < 1 || MAX_MIN > 99) begin : g_bad_max
            $error("stopwatch_timebase: MAX_MIN must be in 1..99");
        end
    endgenerate

    logic [PW-1:0] r_presc;
    logic          r_running;
    logic          r_ovf;
    logic [3:0]    r_h1, r_h0, r_s1, r_s0, r_m1, r_m0;

    logic          w_tick;
    logic          w_wrap;
    logic [3:0]    w_h1_nx, w_h0_nx, w_s1_nx, w_s0_nx, w_m1_nx, w_m0_nx;

    assign w_tick = r_running && (r_presc == LAST);

    // Ripple carry through the six BCD digits; only evaluated on a tick.
    always_comb begin
        w_h1_nx = r_h1;
        w_h0_nx = r_h0;
        w_s1_nx = r_s1;
        w_s0_nx = r_s0;
        w_m1_nx = r_m1;
        w_m0_nx = r_m0;
        w_wrap  = 1'b0;
        if (w_tick) begin
            if (r_h0 != 4'd9) begin
                w_h0_nx = r_h0 + 4'd1;
            end else begin
                w_h0_nx = 4'd0;
                if (r_h1 != 4'd9) begin
                    w_h1_nx = r_h1 + 4'd1;
                end else begin
                    w_h1_nx = 4'd0;
                    if (r_s0 != 4'd9) begin
                        w_s0_nx = r_s0 + 4'd1;
                    end else begin
                        w_s0_nx = 4'd0;
                        if (r_s1 != 4'd5) begin
                            w_s1_nx = r_s1 + 4'd1;
                        end else begin
                            w_s1_nx = 4'd0;
                            if (r_m1 == MAX_T && r_m0 == MAX_U) begin
                                w_m1_nx = 4'd0;
                                w_m0_nx = 4'd0;
                                w_wrap  = 1'b1;
                            end else if (r_m0 != 4'd9) begin
                                w_m0_nx = r_m0 + 4'd1;
                            end else begin
                                w_m0_nx = 4'd0;
                                w_m1_nx = r_m1 + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_presc   <= '0;
            r_running <= 1'b0;
            r_ovf     <= 1'b0;
            r_h1      <= 4'd0;
            r_h0      <= 4'd0;
            r_s1      <= 4'd0;
            r_s0      <= 4'd0;
            r_m1      <= 4'd0;
            r_m0      <= 4'd0;
        end else begin
            if (start_stop) begin
                r_running <= ~r_running;
            end
            // Clear wins over a coincident tick: nothing advances this edge.
            if (clear) begin
                r_presc <= '0;
                r_ovf   <= 1'b0;
                r_h1    <= 4'd0;
                r_h0    <= 4'd0;
                r_s1    <= 4'd0;
                r_s0    <= 4'd0;
                r_m1    <= 4'd0;
                r_m0    <= 4'd0;
            end else begin
                if (r_running) begin
                    r_presc <= (r_presc == LAST) ? '0 : r_presc + PW'(1);
                end
                if (w_wrap) begin
                    r_ovf <= 1'b1;
                end
                r_h1 <= w_h1_nx;
                r_h0 <= w_h0_nx;
                r_s1 <= w_s1_nx;
                r_s0 <= w_s0_nx;
                r_m1 <= w_m1_nx;
                r_m0 <= w_m0_nx;
            end
        end
    end

    assign running  = r_running;
    assign tick     = w_tick;
    assign overflow = r_ovf;

`ifdef LAP_EN
    logic       r_frozen;
    logic [7:0] r_disp_h, r_disp_s, r_disp_m;

    // Snapshot takes the digits as shown during the lap cycle, before any same-edge tick.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_frozen <= 1'b0;
            r_disp_h <= 8'd0;
            r_disp_s <= 8'd0;
            r_disp_m <= 8'd0;
        end else if (clear) begin
            r_frozen <= 1'b0;
        end else if (lap) begin
            r_frozen <= ~r_frozen;
            if (!r_frozen) begin
                r_disp_h <= {r_h1, r_h0};
                r_disp_s <= {r_s1, r_s0};
                r_disp_m <= {r_m1, r_m0};
            end
        end
    end

    assign frozen         = r_frozen;
    assign hundredths_bcd = r_frozen ? r_disp_h : {r_h1, r_h0};
    assign seconds_bcd    = r_frozen ? r_disp_s : {r_s1, r_s0};
    assign minutes_bcd    = r_frozen ? r_disp_m : {r_m1, r_m0};
`else
    logic w_lap_unused;
    assign w_lap_unused   = lap;
    assign frozen         = 1'b0;
    assign hundredths_bcd = {r_h1, r_h0};
    assign seconds_bcd    = {r_s1, r_s0};
    assign minutes_bcd    = {r_m1, r_m0};
`endif

endmodule
